// File: rtl/ptx_serializer.sv
// ptx_serializer: transmit-side parallel-to-serial converter.
//
// Takes bytes over a valid/ready handshake and shifts them out MSB-first,
// one bit per clk_32f. After reset it first sends COMMA_COUNT COMMA symbols
// so the far-end receiver can lock. After that it sends a data byte when
// one is waiting and the IDLE symbol otherwise.
//
// Ports:
//   clk_32f      in   bit clock; all logic is on the rising edge
//   reset        in   synchronous, active-high reset
//   data_in      in   [7:0] byte to transmit
//   valid_in     in   data_in is valid
//   ready_out    out  byte accepted this cycle when valid_in is also high
//                     (combinational)
//   data_out     out  registered serial bit stream
//   symbol_start out  registered; high while data_out carries bit 7 of a symbol
//   active_tx    out  registered; high once the COMMA preamble has completed
module ptx_serializer #(
  parameter int         COMMA_COUNT = 4,
  parameter logic [7:0] COMMA_SYM   = 8'hBC,
  parameter logic [7:0] IDLE_SYM    = 8'h7C
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       symbol_start,
  output logic       active_tx
);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LAST_COMMA = 4'(COMMA_COUNT - 1);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] sym_reg;
  logic [3:0] comma_cnt;
  logic [7:0] hold_reg;
  logic       hold_full;

  logic slot_end;
  logic last_sync;
  logic pop;
  logic accept;

  // The edge with bit_cnt==7 ends the current symbol slot and loads the next.
  // In the last preamble slot the held byte may already go out, so that slot
  // pops exactly like a RUN slot.
  always_comb begin
    slot_end  = (bit_cnt == 3'd7);
    last_sync = (state == SYNC) && (comma_cnt == LAST_COMMA);
    pop       = slot_end && hold_full && ((state == RUN) || last_sync);
    accept    = valid_in && ready_out;
  end

  // A pop frees the buffer on the same edge, so a new byte can be taken in
  // parallel; this keeps back-to-back bytes gap-free.
  assign ready_out = !hold_full || pop;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the pre-edge value of the registers.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state        <= SYNC;
      bit_cnt      <= 3'd0;
      sym_reg      <= COMMA_SYM;
      comma_cnt    <= 4'd0;
      hold_reg     <= 8'h00;
      hold_full    <= 1'b0;
      data_out     <= 1'b0;
      symbol_start <= 1'b0;
      active_tx    <= 1'b0;
    end else begin
      data_out     <= sym_reg[3'd7 - bit_cnt];
      symbol_start <= (bit_cnt == 3'd0);
      bit_cnt      <= bit_cnt + 3'd1;

      if (slot_end) begin
        if ((state == SYNC) && !last_sync) begin
          sym_reg   <= COMMA_SYM;
          comma_cnt <= comma_cnt + 4'd1;
        end else begin
          state     <= RUN;
          active_tx <= 1'b1;
          sym_reg   <= pop ? hold_reg : IDLE_SYM;
        end
      end

      // Accept takes priority: on a simultaneous pop the old byte has already
      // moved to sym_reg above and the buffer stays full with the new one.
      if (accept) begin
        hold_reg  <= data_in;
        hold_full <= 1'b1;
      end else if (pop) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ptx_serializer.sv
// tb_ptx_serializer: self-checking bench for ptx_serializer.
//
// A behavioural model works in terms of edge index k since reset release:
// symbol floor(k/8) is on the wire, bit 7-(k mod 8) of it, and the next
// symbol is chosen at each slot end from a one-deep byte queue. Every cycle
// the DUT outputs are compared against it; a few literal symbol values pin
// the model for the directed scenarios.
module tb_ptx_serializer;

  localparam int         CC    = 4;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [7:0] IDLE  = 8'h7C;

  logic       clk_32f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       data_out;
  logic       symbol_start;
  logic       active_tx;

  ptx_serializer #(
    .COMMA_COUNT(CC),
    .COMMA_SYM  (COMMA),
    .IDLE_SYM   (IDLE)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .data_out    (data_out),
    .symbol_start(symbol_start),
    .active_tx   (active_tx)
  );

  always #5 clk_32f = ~clk_32f;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int         m_k = -1;       // index of the last non-reset edge (-1: none yet)
  bit         m_init = 1'b0;  // model meaningful once a reset edge has happened
  logic [7:0] m_cur = COMMA;  // symbol in the slot the next edge falls into
  logic [7:0] m_hold[$];      // pending input byte (at most one)
  logic       e_data = 1'b0;
  logic       e_ss = 1'b0;
  logic       e_act = 1'b0;
  int         m_bit = 0;
  int         m_slot = 0;

  // Symbols reassembled from the DUT serial output, per slot since reset.
  logic [7:0] dut_sym[64];
  logic [7:0] rx_shift = 8'h00;

  bit   last_acc = 1'b0;
  logic probe_ready = 1'bx;
  logic [7:0] src[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Ready per the handshake rules: free buffer, or the byte in it leaves on
  // the coming edge (a slot end at or after the last preamble slot).
  function automatic logic model_ready();
    int nk;
    nk = m_k + 1;
    if (m_hold.size() == 0) return 1'b1;
    return ((nk % 8) == 7) && ((nk / 8) + 1 >= CC);
  endfunction

  // One clock: check ready before the edge, advance the model on the edge,
  // check registered outputs 1 ns after it.
  task automatic tick();
    bit         acc;
    logic [7:0] din;
    int         nk;
    if (m_init) check("ready_out", ready_out, model_ready());
    acc = valid_in && !reset && model_ready();
    din = data_in;
    @(posedge clk_32f);
    if (reset) begin
      m_k = -1;
      m_hold.delete();
      e_data = 1'b0;
      e_ss = 1'b0;
      e_act = 1'b0;
      m_cur = COMMA;
      m_init = 1'b1;
      foreach (dut_sym[i]) dut_sym[i] = 8'hxx;
    end else begin
      nk = m_k + 1;
      m_bit = nk % 8;
      m_slot = nk / 8;
      e_data = m_cur[7 - m_bit];
      e_ss = (m_bit == 0);
      if (m_bit == 7) begin
        if (m_slot + 1 < CC) m_cur = COMMA;
        else begin
          e_act = 1'b1;
          m_cur = (m_hold.size() != 0) ? m_hold.pop_front() : IDLE;
        end
      end
      if (acc) m_hold.push_back(din);
      m_k = nk;
    end
    last_acc = acc;
    #1;
    if (m_init) begin
      check("data_out", data_out, e_data);
      check("symbol_start", symbol_start, e_ss);
      check("active_tx", active_tx, e_act);
      if (m_hold.size() > 1) check("model_hold_depth", m_hold.size(), 1);
    end
    if (!reset) begin
      rx_shift = {rx_shift[6:0], data_out};
      if (m_bit == 7 && m_slot < 64) dut_sym[m_slot] = rx_shift;
    end
  endtask

  // Two reset cycles, then n_edges edges E0..E(n-1). Bytes in src are offered
  // from edge start_e on, each held until accepted. probe_e captures ready_out
  // just before that edge.
  task automatic scenario(input int start_e, input int n_edges, input int probe_e);
    reset = 1'b1;
    valid_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int e = 0; e < n_edges; e++) begin
      if (e >= start_e && src.size() != 0) begin
        valid_in = 1'b1;
        data_in = src[0];
      end else begin
        valid_in = 1'b0;
      end
      if (e == probe_e) probe_ready = ready_out;
      tick();
      if (last_acc) void'(src.pop_front());
    end
    valid_in = 1'b0;
  endtask

  initial begin
    bit presenting;

    // 1: idle preamble then IDLE fill.
    src.delete();
    scenario(0, 64, 31);
    for (int s = 0; s < 4; s++) check("s1_comma", dut_sym[s], 8'hBC);
    for (int s = 4; s < 8; s++) check("s1_idle", dut_sym[s], 8'h7C);
    check("s1_active_after_E31", active_tx, 1'b1);

    // 2: single byte in RUN.
    src = '{8'hA5};
    scenario(40, 64, -1);
    check("s2_idle_before", dut_sym[5], 8'h7C);
    check("s2_byte", dut_sym[6], 8'hA5);
    check("s2_idle_after", dut_sym[7], 8'h7C);

    // 3: back-to-back bytes from E33.
    src = '{8'h01, 8'h02, 8'h03};
    scenario(33, 72, 40);
    check("s3_idle", dut_sym[4], 8'h7C);
    check("s3_b0", dut_sym[5], 8'h01);
    check("s3_b1", dut_sym[6], 8'h02);
    check("s3_b2", dut_sym[7], 8'h03);
    check("s3_ready_low_mid_slot", probe_ready, 1'b0);

    // 4: byte offered during the preamble goes out as symbol 4.
    src = '{8'h3C};
    scenario(5, 48, 20);
    check("s4_comma", dut_sym[3], 8'hBC);
    check("s4_byte", dut_sym[4], 8'h3C);
    check("s4_ready_low_in_sync", probe_ready, 1'b0);

    // 5: COMMA-valued data byte is sent unmodified.
    src = '{8'hBC};
    scenario(40, 64, -1);
    check("s5_byte_bc", dut_sym[6], 8'hBC);
    check("s5_active", active_tx, 1'b1);

    // 6: reset with a byte held discards it and restarts the preamble.
    src = '{8'h5A};
    scenario(40, 44, -1);
    reset = 1'b1;
    tick();
    check("s6_rst_data_out", data_out, 1'b0);
    check("s6_rst_active", active_tx, 1'b0);
    check("s6_rst_ready", ready_out, 1'b1);
    reset = 1'b0;
    src.delete();
    for (int e = 0; e < 64; e++) tick();
    check("s6_comma0", dut_sym[0], 8'hBC);
    check("s6_comma3", dut_sym[3], 8'hBC);
    for (int s = 4; s < 8; s++) check("s6_no_stale_byte", dut_sym[s], 8'h7C);

    // 7: random traffic with sparse random resets.
    presenting = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        presenting = 1'b0;
      end else begin
        reset = 1'b0;
        if (!presenting && ($urandom_range(0, 2) == 0)) begin
          presenting = 1'b1;
          data_in = 8'($urandom);
        end
      end
      valid_in = presenting;
      tick();
      if (last_acc) presenting = 1'b0;
    end
    valid_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
